serial_subtractor: RTL

//   Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 23 ++
 rtl/full_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// ----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//     - state_t    : controller state encoding (IDLE, SHIFT, DONE)
//     - cnt_width  : width of the bit counter for a given operand width
// ----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter must be able to hold 0..WIDTH-1; WIDTH+1 keeps WIDTH=1
    // at a legal one-bit counter.
    function automatic int cnt_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// ----------------------------------------------------------------------------
// full_subtractor
//   Purely combinational 1-bit full subtractor cell: a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in
//     d    out 1  difference bit
//     bout out 1  borrow out
// ----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when they are equal and a borrow comes in.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit
//   per clock, LSB first, with a start/busy/done handshake.
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow
//   output ovf.
//   Ports:
//     clk    in   1      clock, rising edge
//     rst_n  in   1      asynchronous active-low reset
//     start  in   1      request, honoured only when not busy
//     a      in   WIDTH  minuend, captured on accepted start
//     b      in   WIDTH  subtrahend, captured on accepted start
//     bin    in   1      borrow in, captured on accepted start
//     busy   out  1      high while bits are being shifted
//     done   out  1      one-cycle pulse when diff/bout are fresh
//     diff   out  WIDTH  a - b - bin mod 2^WIDTH, held until next result
//     bout   out  1      final borrow (a < b + bin, unsigned)
//     ovf    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_reg;
    state_t           state_next;
    logic             accept;
    logic             last_shift;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             br_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             cell_d;
    logic             cell_bo;

    // ------------------------------------------------------------------
    // The single subtractor cell works on the current LSBs and the
    // registered borrow.
    // ------------------------------------------------------------------
    full_subtractor u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (br_reg),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // New difference bits enter at the MSB so that after WIDTH shifts the
    // LSB-first stream lines up with bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = cell_d;
        end else begin : g_res_wn
            assign res_next = {cell_d, res_reg[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        last_shift = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    last_shift = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                // A start here chains the next operation without an idle gap.
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. The result is assembled in res_reg and only copied to the
    // visible outputs on the last shift, so diff/bout stay stable while a
    // new operation is in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            br_reg  <= 1'b0;
            cnt_reg <= '0;
            diff    <= '0;
            bout    <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            res_reg <= '0;
            br_reg  <= bin;
            cnt_reg <= '0;
        end else if (state_reg == ST_SHIFT) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            res_reg <= res_next;
            br_reg  <= cell_bo;
            cnt_reg <= cnt_reg + CNT_ONE;
            if (last_shift) begin
                diff <= res_next;
                bout <= cell_bo;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside because the shift registers have
    // consumed them by the time the result is complete. On the last shift
    // cell_d is the result sign bit.
    logic a_msb_reg;
    logic b_msb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if (last_shift) begin
            ovf <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
        end
    end
`endif

endmodule
